// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a streaming 5x5 convolution engine: holds the kernel, issues pixel reads,
// appends the padding flush and collects the engine's results into an indexed output stream.
module conv_frame_ctrl #(
  parameter int unsigned D          = 299,
  parameter int unsigned data_width = 32,
  parameter int unsigned AW         = 17,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       stall,
  input  logic                       kw_valid,
  input  logic [4:0]                 kw_idx,
  input  logic [data_width-1:0]      kw_data,
  output logic [25*data_width-1:0]   kernel_flat,
  output logic                       rd_en,
  output logic [AW-1:0]              rd_addr,
  input  logic [data_width-1:0]      rd_data,
  output logic                       conv_valid_in,
  output logic [data_width-1:0]      conv_pxl_in,
  input  logic                       conv_valid_out,
  input  logic [data_width-1:0]      conv_pxl_out,
  output logic                       out_valid,
  output logic [data_width-1:0]      out_data,
  output logic [AW-1:0]              out_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned NPix   = D * D;
  localparam int unsigned NFlush = 2 * D + 2;
  localparam int unsigned CntW   = AW + 1;
  localparam int unsigned FlW    = $clog2(NFlush + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0]   LastAddr = AW'(NPix - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(NPix);
  localparam logic [CntW-1:0] CntLast  = CntW'(NPix - 1);
  localparam logic [FlW-1:0]  FlLast   = FlW'(NFlush - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StStream, StFlush, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [FlW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [CntW-1:0]       out_cnt_q, out_cnt_d;
  logic [ToW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic                  in_vld_q, in_vld_d;
  logic                  in_pad_q, in_pad_d;
  logic                  out_vld_q, out_vld_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         out_idx_q, out_idx_d;
  logic [data_width-1:0] kernel_q [25];

  logic active, issue_rd, issue_pad, take_out, last_out;

  always_comb begin
    active    = (state_q == StStream) || (state_q == StFlush) || (state_q == StWait);
    issue_rd  = (state_q == StStream) && !stall;
    issue_pad = (state_q == StFlush) && !stall;
    // Results past the frame size or outside an active frame are dropped.
    take_out  = active && conv_valid_out && (out_cnt_q < CntMax);
    last_out  = take_out && (out_cnt_q == CntLast);
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    flush_cnt_d = flush_cnt_q;
    out_cnt_d   = out_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    in_vld_d    = issue_rd | issue_pad;
    in_pad_d    = issue_pad;
    out_vld_d   = take_out;
    out_data_d  = take_out ? conv_pxl_out : out_data_q;
    out_idx_d   = take_out ? out_cnt_q[AW-1:0] : out_idx_q;

    if (take_out) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d     = StStream;
          rd_addr_d   = '0;
          flush_cnt_d = '0;
          out_cnt_d   = '0;
          wait_cnt_d  = '0;
          err_d       = 1'b0;
        end
      end
      StStream: begin
        if (issue_rd) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LastAddr) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (issue_pad) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FlLast) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A completed frame beats a timeout landing on the same cycle.
    if (last_out) begin
      state_d = StDone;
      err_d   = err_q;
    end

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      in_vld_d  = 1'b0;
      out_vld_d = 1'b0;
      err_d     = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      flush_cnt_q <= '0;
      out_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      in_vld_q    <= 1'b0;
      in_pad_q    <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      flush_cnt_q <= flush_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      in_vld_q    <= in_vld_d;
      in_pad_q    <= in_pad_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 25; k++) begin
        kernel_q[k] <= '0;
      end
    end else if ((state_q == StIdle) && kw_valid && (kw_idx < 5'd25)) begin
      kernel_q[kw_idx] <= kw_data;
    end
  end

  for (genvar k = 0; k < 25; k++) begin : g_kflat
    assign kernel_flat[k*data_width +: data_width] = kernel_q[k];
  end

  // Read data lands one cycle after rd_en; padding slots substitute zero for it.
  assign conv_valid_in = in_vld_q;
  assign conv_pxl_in   = (in_vld_q && !in_pad_q) ? rd_data : '0;
  assign rd_en         = issue_rd;
  assign rd_addr       = rd_addr_q;
  assign out_valid     = out_vld_q;
  assign out_data      = out_data_q;
  assign out_idx       = out_idx_q;
  assign busy          = active;
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with D=4, a registered pixel memory and an
// identity engine model delayed 2*D+3 cycles.
module tb_conv_frame_ctrl;

  localparam int D   = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int TO  = 16;
  localparam int LAT = 2 * D + 3;

  logic              clk;
  logic              reset, start, abort, stall, kw_valid;
  logic [4:0]        kw_idx;
  logic [DW-1:0]     kw_data;
  logic [25*DW-1:0]  kernel_flat;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              conv_valid_in;
  logic [DW-1:0]     conv_pxl_in;
  logic              conv_valid_out;
  logic [DW-1:0]     conv_pxl_out;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_idx;
  logic              busy, done, err;

  conv_frame_ctrl #(.D(D), .data_width(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .kw_valid(kw_valid), .kw_idx(kw_idx), .kw_data(kw_data), .kernel_flat(kernel_flat),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_valid_in(conv_valid_in), .conv_pxl_in(conv_pxl_in),
    .conv_valid_out(conv_valid_out), .conv_pxl_out(conv_pxl_out),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input int i);
    return 32'h4000_0100 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem_val(int'(rd_addr));
  end

  // Engine model
  logic          eng_en;
  logic [LAT-1:0] eng_v;
  logic [DW-1:0] eng_d [LAT];
  always @(posedge clk) begin
    if (reset) eng_v <= '0;
    else eng_v <= {eng_v[LAT-2:0], conv_valid_in};
    eng_d[0] <= conv_pxl_in;
    for (int i = 1; i < LAT; i++) eng_d[i] <= eng_d[i-1];
  end
  assign conv_valid_out = eng_v[LAT-1] & eng_en;
  assign conv_pxl_out   = eng_d[LAT-1];

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-frame observation counters
  logic mon_clr;
  int rd_n, rd_addr_bad, rd_gap, rd_last, stall_rd, pad_n, out_n, out_bad, done_n, busy_n;
  always @(negedge clk) begin
    if (mon_clr) begin
      rd_n <= 0; rd_addr_bad <= 0; rd_gap <= 0; rd_last <= 0; stall_rd <= 0;
      pad_n <= 0; out_n <= 0; out_bad <= 0; done_n <= 0; busy_n <= 0;
    end else begin
      if (rd_en) begin
        rd_n <= rd_n + 1;
        if (rd_addr != AW'(rd_n)) rd_addr_bad <= rd_addr_bad + 1;
        if (rd_n != 0 && cyc != rd_last + 1) rd_gap <= rd_gap + 1;
        rd_last <= cyc;
        if (stall) stall_rd <= stall_rd + 1;
      end
      if (conv_valid_in && conv_pxl_in == '0) pad_n <= pad_n + 1;
      if (out_valid) begin
        out_n <= out_n + 1;
        if (out_idx != AW'(out_n) || out_data != mem_val(out_n)) out_bad <= out_bad + 1;
      end
      if (done) done_n <= done_n + 1;
      if (busy) busy_n <= busy_n + 1;
    end
  end

  int n_vec, n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_cvin"}, conv_valid_in, 0);
    check({tag, "_cpxl"}, conv_pxl_in, 0);
    check({tag, "_outv"}, out_valid, 0);
    check({tag, "_outd"}, out_data, 0);
    check({tag, "_outi"}, out_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_kzero"}, kernel_flat == '0, 1);
  endtask

  task automatic run_frame(input bit stall_alt, input bit kw_inject, input int budget,
                           output bit timed_out);
    bit fin;
    fin = 1'b0;
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (stall_alt) stall = ~stall;
      kw_valid = kw_inject && (n == 3);
      kw_idx   = 5'd0;
      kw_data  = 32'hdead_beef;
      step();
      if (done_n != 0) begin
        fin = 1'b1;
        break;
      end
    end
    stall    = 1'b0;
    kw_valid = 1'b0;
    step();
    step();
    timed_out = !fin;
  endtask

  typedef struct {
    logic        kv;
    logic [4:0]  idx;
    logic [31:0] data;
    int          chk;
    logic [31:0] exp;
  } kvec_t;

  kvec_t tbl[28];
  logic [25*DW-1:0] exp_flat;
  bit to;
  bit found;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 0; abort = 0; stall = 0; kw_valid = 0; kw_idx = 0; kw_data = 0;
    eng_en = 1'b1; mon_clr = 1'b0;

    for (int k = 0; k < 25; k++) tbl[k] = '{1'b1, 5'(k), 32'h3f80_0000, k, 32'h3f80_0000};
    tbl[25] = '{1'b1, 5'd31, 32'h4000_0000, 24, 32'h3f80_0000};
    tbl[26] = '{1'b1, 5'd31, 32'h4000_0000, 0, 32'h3f80_0000};
    tbl[27] = '{1'b0, 5'd5, 32'h1234_5678, 5, 32'h3f80_0000};
    for (int k = 0; k < 25; k++) exp_flat[k*DW +: DW] = 32'h3f80_0000;

    step(); step();
    check_zero("reset");
    reset = 1'b0;
    clear_mon();

    // Kernel loading
    for (int i = 0; i < 28; i++) begin
      kw_valid = tbl[i].kv; kw_idx = tbl[i].idx; kw_data = tbl[i].data;
      step();
      kw_valid = 1'b0;
      check($sformatf("kw_vec%0d", i), kernel_flat[tbl[i].chk*DW +: DW], tbl[i].exp);
    end
    check("kflat_all", kernel_flat == exp_flat, 1);

    // Clean frame, no stall
    run_frame(1'b0, 1'b0, 200, to);
    check("f1_timeout", to, 0);
    check("f1_rd_n", rd_n, 16);
    check("f1_rd_addr", rd_addr_bad, 0);
    check("f1_rd_gap", rd_gap, 0);
    check("f1_pad_n", pad_n, 10);
    check("f1_out_n", out_n, 16);
    check("f1_out_bad", out_bad, 0);
    check("f1_done_n", done_n, 1);
    check("f1_busy_n", busy_n, 28);
    check("f1_busy_end", busy, 0);
    check("f1_err", err, 0);
    idle(20);

    // Alternating stall
    run_frame(1'b1, 1'b0, 300, to);
    check("f2_timeout", to, 0);
    check("f2_stall_rd", stall_rd, 0);
    check("f2_rd_n", rd_n, 16);
    check("f2_rd_addr", rd_addr_bad, 0);
    check("f2_out_n", out_n, 16);
    check("f2_out_bad", out_bad, 0);
    check("f2_done_n", done_n, 1);
    idle(20);

    // Silent engine: timeout path, kernel writes ignored mid-frame
    eng_en = 1'b0;
    run_frame(1'b0, 1'b1, 200, to);
    check("f3_timeout", to, 0);
    check("f3_err", err, 1);
    check("f3_done_n", done_n, 1);
    check("f3_out_n", out_n, 0);
    check("f3_busy_n", busy_n, 42);
    check("f3_k0", kernel_flat[0 +: DW], 32'h3f80_0000);
    idle(3);
    check("f3_err_sticky", err, 1);
    eng_en = 1'b1;
    idle(20);

    // Abort together with start at rd_addr 7
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rd_addr == 4'd7) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("ab_reach7", found, 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_cvin", conv_valid_in, 0);
    check("ab_outv", out_valid, 0);
    check("ab_done", done, 0);
    check("ab_rd_en", rd_en, 0);
    idle(20);
    check("ab_done_n", done_n, 0);
    check("ab_out_n", out_n, 0);
    check("ab_err", err, 0);
    run_frame(1'b0, 1'b0, 200, to);
    check("ab2_timeout", to, 0);
    check("ab2_out_n", out_n, 16);
    check("ab2_out_bad", out_bad, 0);
    check("ab2_done_n", done_n, 1);
    idle(20);

    // Reset during flush
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    idle(19);
    check("fl_busy", busy, 1);
    check("fl_pad", conv_valid_in && conv_pxl_in == '0 && !rd_en, 1);
    reset = 1'b1;
    step();
    check_zero("midrst");
    reset = 1'b0;
    idle(20);
    check("midrst_done_n", done_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
